// File: rtl/ring_ro_pkg.sv
// Shared types and constants for the ring-buffer readout sequencer.
package ring_ro_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_BACK = 1'b0;
    localparam logic DIR_FWD  = 1'b1;

    localparam int ADDR_W_DEF = 12;
    localparam int CNT_W_DEF  = 12;

    // Channel-select width; a single-channel build still carries one bit.
    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/ring_ro_sequencer_if.sv
// Control/request and RAM-side signals of the readout sequencer.
interface ring_ro_sequencer_if
    import ring_ro_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int NCH    = 4
);
    localparam int CH_W = ch_width(NCH);

    logic [ADDR_W-1:0] ain;
    logic [ADDR_W-1:0] offset_i;
    logic [CNT_W-1:0]  howmany_i;
    logic [NCH-1:0]    ch_mask_i;
    logic              dir_i;
    logic              start;
    logic              abort;
    logic              SPI_done;
    logic [ADDR_W-1:0] address;
    logic [CH_W-1:0]   ch_sel;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              ro_done_n;

    // Sequencer side
    modport slave (
        input  ain, offset_i, howmany_i, ch_mask_i, dir_i, start, abort, SPI_done,
        output address, ch_sel, rd_valid, busy, done, ro_done_n
    );

    // Trigger/SPI control side
    modport master (
        output ain, offset_i, howmany_i, ch_mask_i, dir_i, start, abort, SPI_done,
        input  address, ch_sel, rd_valid, busy, done, ro_done_n
    );
endinterface

// File: rtl/ring_ro_sequencer_next_ch_find.sv
// Finds the next higher enabled channel above cur (or the lowest one when first=1).
module next_ch_find
    import ring_ro_pkg::*;
#(
    parameter int NCH = 4,
    localparam int CH_W = ch_width(NCH)
) (
    input  logic [NCH-1:0]  mask,
    input  logic [CH_W-1:0] cur,
    input  logic            first,
    output logic [CH_W-1:0] nxt,
    output logic            none
);
    // Scan from the top down so the lowest qualifying index wins.
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt  = CH_W'(i);
                none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/ring_ro_sequencer.sv
// Multi-channel ring-buffer readout sequencer: walks one address window per
// enabled channel, one word per SPI_done acknowledge.
module ring_ro_sequencer
    import ring_ro_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int NCH    = 4
) (
    input  logic               sysclk,
    input  logic               rst_n,
    ring_ro_sequencer_if.slave bus
);
    localparam int CH_W = ch_width(NCH);
    // The word count must be able to hold DEPTH itself after clamping.
    localparam int N_W = (CNT_W > ADDR_W) ? CNT_W : ADDR_W + 1;
    localparam logic [N_W-1:0] DEPTH_N = N_W'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ro_done_n_q, ro_done_n_d;
    logic [N_W-1:0]    rem_q, rem_d;
    logic [N_W-1:0]    n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [NCH-1:0]    mask_q, mask_d;
    logic              dir_q, dir_d;

    logic [N_W-1:0]    hm_w, n_start;
    logic [ADDR_W-1:0] base_start;
    logic [NCH-1:0]    find_mask;
    logic              find_first;
    logic [CH_W-1:0]   find_nxt;
    logic              find_none;

    // Request-time word count and window base (everything wraps mod DEPTH).
    always_comb begin
        hm_w       = N_W'(bus.howmany_i);
        n_start    = (hm_w > DEPTH_N) ? DEPTH_N : hm_w;
        base_start = (bus.dir_i == DIR_FWD)
                   ? (bus.ain - bus.offset_i - n_start[ADDR_W-1:0])
                   : (bus.ain - bus.offset_i - ADDR_W'(1));
    end

    // In IDLE the search runs on the live mask to pick the first channel.
    assign find_first = (state_q == IDLE);
    assign find_mask  = (state_q == IDLE) ? bus.ch_mask_i : mask_q;

    next_ch_find #(.NCH(NCH)) u_find (
        .mask  (find_mask),
        .cur   (ch_q),
        .first (find_first),
        .nxt   (find_nxt),
        .none  (find_none)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        ch_d       = ch_q;
        rd_valid_d = rd_valid_q;
        done_d     = 1'b0;
        rem_d      = rem_q;
        n_d        = n_q;
        base_d     = base_q;
        mask_d     = mask_q;
        dir_d      = dir_q;

        case (state_q)
            IDLE: begin
                address_d  = '0;
                ch_d       = '0;
                rd_valid_d = 1'b0;
                rem_d      = '0;
                if (bus.start && !bus.abort) begin
                    n_d    = n_start;
                    base_d = base_start;
                    mask_d = bus.ch_mask_i;
                    dir_d  = bus.dir_i;
                    if ((n_start == '0) || find_none) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = READ;
                        ch_d       = find_nxt;
                        address_d  = base_start;
                        rem_d      = n_start;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (bus.abort) begin
                    state_d    = IDLE;
                    address_d  = '0;
                    ch_d       = '0;
                    rd_valid_d = 1'b0;
                    rem_d      = '0;
                end else if (bus.SPI_done) begin
                    if (rem_q == N_W'(1)) begin
                        if (find_none) begin
                            state_d    = DONE;
                            done_d     = 1'b1;
                            address_d  = '0;
                            ch_d       = '0;
                            rd_valid_d = 1'b0;
                            rem_d      = '0;
                        end else begin
                            // Channel switch reloads the window with no bubble.
                            ch_d      = find_nxt;
                            address_d = base_q;
                            rem_d     = n_q;
                        end
                    end else begin
                        rem_d     = rem_q - N_W'(1);
                        address_d = (dir_q == DIR_FWD) ? (address_q + ADDR_W'(1))
                                                       : (address_q - ADDR_W'(1));
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                address_d  = '0;
                ch_d       = '0;
                rd_valid_d = 1'b0;
                rem_d      = '0;
            end
            default: begin
                state_d    = IDLE;
                address_d  = '0;
                ch_d       = '0;
                rd_valid_d = 1'b0;
                rem_d      = '0;
            end
        endcase

        busy_d      = (state_d != IDLE);
        ro_done_n_d = (state_d == READ) && (rem_d != '0);
    end

    // State, counters, latched request and registered outputs.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            address_q   <= '0;
            ch_q        <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ro_done_n_q <= 1'b0;
            rem_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            mask_q      <= '0;
            dir_q       <= DIR_BACK;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            ch_q        <= ch_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ro_done_n_q <= ro_done_n_d;
            rem_q       <= rem_d;
            n_q         <= n_d;
            base_q      <= base_d;
            mask_q      <= mask_d;
            dir_q       <= dir_d;
        end
    end

    assign bus.address   = address_q;
    assign bus.ch_sel    = ch_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ro_done_n = ro_done_n_q;
endmodule

// File: tb/tb_ring_ro_sequencer.sv
// Randomised bench for ring_ro_sequencer against a word-list reference model.
module tb_ring_ro_sequencer;
    localparam int DEPTH = 4096;

    typedef struct {
        int ch;
        int addr;
    } word_t;

    logic sysclk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    word_t exp_q[$];

    ring_ro_sequencer_if #(.ADDR_W(12), .CNT_W(12), .NCH(4)) bus ();

    ring_ro_sequencer #(.ADDR_W(12), .CNT_W(12), .NCH(4)) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected word list: every enabled channel in ascending order, N words each.
    function automatic void build(input int a, input int off, input int hm, input int m, input int d);
        int n;
        int ad;
        exp_q.delete();
        n = (hm > DEPTH) ? DEPTH : hm;
        for (int c = 0; c < 4; c++) begin
            if (((m >> c) & 1) != 0) begin
                for (int j = 0; j < n; j++) begin
                    ad = (d != 0) ? (a - off - n + j) : (a - off - 1 - j);
                    ad = ((ad % DEPTH) + DEPTH) % DEPTH;
                    exp_q.push_back('{ch: c, addr: ad});
                end
            end
        end
    endfunction

    task automatic scramble();
        bus.ain       = 12'($urandom);
        bus.offset_i  = 12'($urandom);
        bus.howmany_i = 12'($urandom);
        bus.ch_mask_i = 4'($urandom);
        bus.dir_i     = 1'($urandom);
    endtask

    task automatic issue(input int a, input int off, input int hm, input int m, input int d);
        build(a, off, hm, m, d);
        @(negedge sysclk);
        bus.ain       = 12'(a);
        bus.offset_i  = 12'(off);
        bus.howmany_i = 12'(hm);
        bus.ch_mask_i = 4'(m);
        bus.dir_i     = 1'(d);
        bus.start     = 1'b1;
        @(negedge sysclk);
        bus.start = 1'b0;
        scramble();
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    // One cycle of a running readout: compare the presented word, optionally ack it.
    task automatic step(input logic ack, input logic noise);
        chk("rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("address", 32'(bus.address), 32'(exp_q[0].addr));
        chk("ch_sel", 32'(bus.ch_sel), 32'(exp_q[0].ch));
        chk("ro_done_n", 32'(bus.ro_done_n), 32'd1);
        chk("done_early", 32'(bus.done), 32'd0);
        bus.SPI_done = ack;
        if (noise) begin
            bus.start = ($urandom_range(7) == 0);
            scramble();
        end
        @(negedge sysclk);
        bus.SPI_done = 1'b0;
        bus.start    = 1'b0;
        if (ack) void'(exp_q.pop_front());
    endtask

    task automatic run_ro(input int a, input int off, input int hm, input int m, input int d,
                          input int gap, input logic noise);
        int budget;
        int cycles;
        issue(a, off, hm, m, d);
        if (exp_q.size() == 0) begin
            chk("empty_done", 32'(bus.done), 32'd1);
            chk("empty_rd_valid", 32'(bus.rd_valid), 32'd0);
            @(negedge sysclk);
            chk("empty_busy_off", 32'(bus.busy), 32'd0);
            chk("empty_done_off", 32'(bus.done), 32'd0);
            chk("empty_rd_valid2", 32'(bus.rd_valid), 32'd0);
            return;
        end
        budget = exp_q.size() * 40 + 20;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < budget) begin
            step($urandom_range(99) >= gap, noise);
            cycles++;
        end
        if (exp_q.size() != 0) begin
            chk("timeout_words_left", 32'(exp_q.size()), 32'd0);
            return;
        end
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_address", 32'(bus.address), 32'd0);
        chk("done_ro_done_n", 32'(bus.ro_done_n), 32'd0);
        @(negedge sysclk);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_address"}, 32'(bus.address), 32'd0);
        chk({tag, "_ch_sel"}, 32'(bus.ch_sel), 32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_ro_done_n"}, 32'(bus.ro_done_n), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.SPI_done = 1'b0;
        scramble();
        repeat (2) @(negedge sysclk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(negedge sysclk);

        // Directed cases from the readout description.
        run_ro(12'h010, 4, 3, 4'b0001, 0, 0, 1'b0);
        run_ro(12'h002, 1, 4, 4'b0001, 1, 0, 1'b0);
        run_ro(12'h105, 4, 2, 4'b1010, 0, 0, 1'b0);
        run_ro(12'h123, 5, 0, 4'b1111, 0, 0, 1'b0);
        run_ro(12'h123, 5, 7, 4'b0000, 1, 0, 1'b0);

        // start together with abort in IDLE does nothing.
        @(negedge sysclk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge sysclk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk_idle("start_abort");

        // Abort after two of five words.
        issue(12'h200, 0, 5, 4'b0001, 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        bus.abort = 1'b1;
        @(negedge sysclk);
        bus.abort = 1'b0;
        chk_idle("abort");
        @(negedge sysclk);
        chk("abort_no_done", 32'(bus.done), 32'd0);
        run_ro(12'h300, 2, 3, 4'b0100, 1, 0, 1'b0);

        // Asynchronous reset in the middle of a readout.
        issue(12'h050, 0, 6, 4'b0110, 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_idle("async_reset");
        @(negedge sysclk);
        rst_n = 1'b1;
        exp_q.delete();
        run_ro(12'h000, 0, 3, 4'b1001, 0, 30, 1'b1);

        // Randomised readouts with irregular acks and ignored start requests.
        for (int t = 0; t < 25; t++) begin
            run_ro($urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1),
                   ($urandom_range(5) == 0) ? 0 : $urandom_range(1, 12),
                   $urandom_range(15), $urandom_range(1), $urandom_range(70), 1'b1);
        end
        run_ro(12'h004, 2, 300, 4'b1111, 1, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
